// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants for the seven-segment scan controller: mux code values,
// active-low segment patterns ({g,f,e,d,c,b,a}, 0 = segment lit) and the
// scan state encoding.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

   // Digit codes returned by the display mux beyond 0..9
   localparam logic [3:0] CODE_BLANK = 4'hA;
   localparam logic [3:0] CODE_DASH  = 4'hB;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   typedef enum logic {
      SCAN_DEAD = 1'b0,
      SCAN_ON   = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
// Combinational 4-bit digit code to active-low segment pattern.
//   code  : in,  4 - digit code (0..9 digits, 4'hB dash, everything else blank)
//   seg_n : out, 7 - {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seven_seg_decoder (
   input  logic [3:0] code,
   output logic [6:0] seg_n
);
   import seven_seg_pkg::*;

   always_comb begin
      seg_n = SEG_BLANK;
      case (code)
         4'd0:      seg_n = SEG_0;
         4'd1:      seg_n = SEG_1;
         4'd2:      seg_n = SEG_2;
         4'd3:      seg_n = SEG_3;
         4'd4:      seg_n = SEG_4;
         4'd5:      seg_n = SEG_5;
         4'd6:      seg_n = SEG_6;
         4'd7:      seg_n = SEG_7;
         4'd8:      seg_n = SEG_8;
         4'd9:      seg_n = SEG_9;
         CODE_DASH: seg_n = SEG_DASH;
         default:   seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for the multi-digit seven-segment display.
// Walks mux_sel from NUM_DIGITS-1 down to 0, one slot of REFRESH_DIV cycles per
// digit. Each slot starts with DEAD_CYCLES of all anodes off (ghosting guard,
// also lets the display mux settle), then captures the returned digit code and
// lights the selected anode for the rest of the slot.
//
// Ports:
//   clk        : in,  1          - system clock
//   rst_n      : in,  1          - asynchronous active-low reset
//   en         : in,  1          - scan enable (0 parks the scan at frame start)
//   digit_data : in,  4          - code of the selected digit from the mux
//   dp_sel     : in,  NUM_DIGITS - decimal-point request per digit, active-high
//   mux_sel    : out, 3          - digit select to the mux
//   an         : out, NUM_DIGITS - common anodes, active-low
//   seg        : out, 7          - {g,f,e,d,c,b,a}, active-low
//   dp_n       : out, 1          - decimal point, active-low
//   frame_tick : out, 1          - one-cycle pulse on wrap back to NUM_DIGITS-1
//
// Build option SEVEN_SEG_LEADING_ZERO_BLANK_EN: blanks leading zeros of the
// frame (digit 0 is always shown).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// SCAN_DEAD | all anodes off, mux_sel settling; ends by capturing seg/dp_n
// SCAN_ON   | selected anode lit with the captured pattern; ends by stepping
//           | mux_sel to the next digit
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS  = 6,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [3:0]            digit_data,
   input  logic [NUM_DIGITS-1:0] dp_sel,
   output logic [2:0]            mux_sel,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic                  frame_tick
);
   import seven_seg_pkg::*;

   localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [2:0]       SEL_FIRST = 3'(NUM_DIGITS - 1);

   scan_state_t           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            mux_sel_d;
   logic [NUM_DIGITS-1:0] an_d;
   logic [6:0]            seg_d;
   logic                  dp_n_d;
   logic                  capture;
   logic                  frame_wrap;
   logic [6:0]            dec_seg;
   logic [6:0]            capture_seg;

   seven_seg_decoder u_decoder (
      .code  (digit_data),
      .seg_n (dec_seg)
   );

   // The slot counter runs 0..REFRESH_DIV-1 across the whole slot; DEAD
   // occupies the first DEAD_CYCLES counts, ON the remainder.
   assign capture    = en && (state_q == SCAN_DEAD) && (cnt_q == DEAD_LAST);
   assign frame_wrap = en && (state_q == SCAN_ON) && (cnt_q == SLOT_LAST)
                       && (mux_sel == 3'd0);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   // Set once a significant digit has been shown in the current frame.
   logic nonzero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nonzero_q <= 1'b0;
      end else if (!en || frame_wrap) begin
         nonzero_q <= 1'b0;
      end else if (capture && (digit_data != 4'h0) && (digit_data != CODE_BLANK)) begin
         nonzero_q <= 1'b1;
      end
   end

   assign capture_seg = ((digit_data == 4'h0) && !nonzero_q && (mux_sel != 3'd0))
                        ? SEG_BLANK : dec_seg;
`else
   assign capture_seg = dec_seg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SCAN_DEAD;
         cnt_q      <= '0;
         mux_sel    <= SEL_FIRST;
         an         <= '1;
         seg        <= SEG_BLANK;
         dp_n       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mux_sel    <= mux_sel_d;
         an         <= an_d;
         seg        <= seg_d;
         dp_n       <= dp_n_d;
         frame_tick <= frame_wrap;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      mux_sel_d = mux_sel;
      seg_d     = seg;
      dp_n_d    = dp_n;

      if (!en) begin
         state_d   = SCAN_DEAD;
         cnt_d     = '0;
         mux_sel_d = SEL_FIRST;
         seg_d     = SEG_BLANK;
         dp_n_d    = 1'b1;
      end else begin
         case (state_q)
            SCAN_DEAD: begin
               // Capture happens only here, so the lit pattern is frozen for
               // the whole ON phase regardless of digit_data activity.
               if (capture) begin
                  state_d = SCAN_ON;
                  seg_d   = capture_seg;
                  dp_n_d  = ~dp_sel[mux_sel];
               end
            end
            SCAN_ON: begin
               if (cnt_q == SLOT_LAST) begin
                  state_d   = SCAN_DEAD;
                  cnt_d     = '0;
                  seg_d     = SEG_BLANK;
                  dp_n_d    = 1'b1;
                  mux_sel_d = (mux_sel == 3'd0) ? SEL_FIRST : mux_sel - 3'd1;
               end
            end
            default: begin
               state_d = SCAN_DEAD;
               cnt_d   = '0;
            end
         endcase
      end

      // Anodes are registered from the next state so the pins change on the
      // same edge as the state, with no decode glitches.
      an_d = '1;
      if (state_d == SCAN_ON) begin
         an_d[mux_sel_d] = 1'b0;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
// Directed bench for seven_seg_scan_ctrl with REFRESH_DIV=8, DEAD_CYCLES=2.
// Stimulus pushes the expected pattern of every lit slot into a scoreboard;
// a negedge monitor pops one entry each time an anode turns on and checks it
// for every ON cycle, and checks the blanked outputs during dead time.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

   localparam int ND = 6;
   localparam int RD = 8;
   localparam int DC = 2;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [3:0]    digit_data;
   logic [ND-1:0] dp_sel;
   logic [2:0]    mux_sel;
   logic [ND-1:0] an;
   logic [6:0]    seg;
   logic          dp_n;
   logic          frame_tick;

   logic [3:0]    mux_digits [ND];

   typedef struct {
      logic [2:0] sel;
      logic [6:0] seg;
      logic       dp_n;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   logic in_on = 1'b0;
   logic [ND-1:0] mon_an_exp;

   int n_checks = 0;
   int n_fail   = 0;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .DEAD_CYCLES (DC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .digit_data (digit_data),
      .dp_sel     (dp_sel),
      .mux_sel    (mux_sel),
      .an         (an),
      .seg        (seg),
      .dp_n       (dp_n),
      .frame_tick (frame_tick)
   );

   // Display mux model: returns the blank code for out-of-range selects.
   always_comb begin
      digit_data = 4'hA;
      if (mux_sel < 3'd6) digit_data = mux_digits[mux_sel];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [2:0] sel, input logic [6:0] s, input logic d);
      exp_t e;
      e.sel  = sel;
      e.seg  = s;
      e.dp_n = d;
      sb_q.push_back(e);
   endtask

   task automatic push_frame(input logic [6:0] s5, input logic [6:0] s4, input logic [6:0] s3,
                             input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
      push(3'd5, s5, 1'b1);
      push(3'd4, s4, 1'b1);
      push(3'd3, s3, 1'b1);
      push(3'd2, s2, 1'b1);
      push(3'd1, s1, 1'b1);
      push(3'd0, s0, 1'b1);
   endtask

   task automatic set_digits(input logic [3:0] d5, input logic [3:0] d4, input logic [3:0] d3,
                             input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
      mux_digits[5] = d5;
      mux_digits[4] = d4;
      mux_digits[3] = d3;
      mux_digits[2] = d2;
      mux_digits[1] = d1;
      mux_digits[0] = d0;
   endtask

   // Enables the scan from frame start and checks slot timing for n cycles.
   // Optionally rewrites one mux entry after cycle chg_at.
   task automatic run_scan(input int n, input int chg_at, input int chg_idx, input logic [3:0] chg_val);
      logic [ND-1:0] an_exp;
      logic [2:0]    sel_exp;
      en = 1'b1;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         sel_exp = 3'(5 - ((i / RD) % ND));
         an_exp  = 6'h3F;
         if ((i % RD) >= DC) an_exp[sel_exp] = 1'b0;
         check("scan_mux_sel", 32'(mux_sel), 32'(sel_exp));
         check("scan_an", 32'(an), 32'(an_exp));
         check("scan_frame_tick", 32'(frame_tick), 32'((i % (RD * ND)) == 0));
         if (i == chg_at) mux_digits[chg_idx] = chg_val;
      end
   endtask

   task automatic idle();
      en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         in_on = 1'b0;
      end else if (an != 6'h3F) begin
         if (!in_on) begin
            in_on = 1'b1;
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow actual=slot_sel_%0d required=no_slot time=%0t", mux_sel, $time);
               cur.sel  = mux_sel;
               cur.seg  = 7'h7F;
               cur.dp_n = 1'b1;
            end else begin
               cur = sb_q.pop_front();
            end
            check("slot_sel", 32'(mux_sel), 32'(cur.sel));
         end
         mon_an_exp = 6'h3F;
         mon_an_exp[cur.sel] = 1'b0;
         check("on_an", 32'(an), 32'(mon_an_exp));
         check("on_seg", 32'(seg), 32'(cur.seg));
         check("on_dp_n", 32'(dp_n), 32'(cur.dp_n));
      end else begin
         in_on = 1'b0;
         check("dead_seg", 32'(seg), 32'h7F);
         check("dead_dp_n", 32'(dp_n), 32'h1);
      end
   end

   initial begin
      rst_n  = 1'b1;
      en     = 1'b0;
      dp_sel = '0;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mux_sel", 32'(mux_sel), 32'd5);
      check("rst_an", 32'(an), 32'h3F);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp_n", 32'(dp_n), 32'h1);
      check("rst_frame_tick", 32'(frame_tick), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Two full frames; digit 5 changes to 8 while its first slot is lit.
      push_frame(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
      push_frame(7'h00, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
      run_scan(96, 4, 5, 4'h8);
      idle();

      // Special codes and a decimal point on digit 2.
      set_digits(4'hA, 4'hB, 4'hF, 4'd3, 4'd7, 4'd9);
      dp_sel = 6'b000100;
      push(3'd5, 7'h7F, 1'b1);
      push(3'd4, 7'h3F, 1'b1);
      push(3'd3, 7'h7F, 1'b1);
      push(3'd2, 7'h30, 1'b0);
      push(3'd1, 7'h78, 1'b1);
      push(3'd0, 7'h10, 1'b1);
      run_scan(48, -1, 0, 4'h0);
      idle();
      dp_sel = '0;

      // Disable in the middle of an ON phase, then restart from frame start.
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      push_frame(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
      push(3'd5, 7'h79, 1'b1);
      push(3'd4, 7'h24, 1'b1);
      run_scan(60, -1, 0, 4'h0);
      en = 1'b0;
      @(posedge clk);
      #1;
      check("en_off_an", 32'(an), 32'h3F);
      check("en_off_mux_sel", 32'(mux_sel), 32'd5);
      check("en_off_seg", 32'(seg), 32'h7F);
      check("en_off_dp_n", 32'(dp_n), 32'h1);
      check("en_off_frame_tick", 32'(frame_tick), 32'h0);
      push_frame(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
      push(3'd5, 7'h79, 1'b1);
      run_scan(56, -1, 0, 4'h0);
      idle();

      // Zeros 0,0,1,0,0,0 then all zeros in the following frame.
      set_digits(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      push_frame(7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40);
      push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
`else
      push_frame(7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40);
      push_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
`endif
      run_scan(96, 48, 3, 4'h0);
      idle();

      // Asynchronous reset in the middle of a lit slot.
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      push(3'd5, 7'h79, 1'b1);
      push(3'd4, 7'h24, 1'b1);
      push(3'd3, 7'h30, 1'b1);
      run_scan(20, -1, 0, 4'h0);
      en    = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_mid_mux_sel", 32'(mux_sel), 32'd5);
      check("rst_mid_an", 32'(an), 32'h3F);
      check("rst_mid_seg", 32'(seg), 32'h7F);
      check("rst_mid_dp_n", 32'(dp_n), 32'h1);
      check("rst_mid_frame_tick", 32'(frame_tick), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      check("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 6-digit seven-segment display.
- Drives the digit-select bus into the display mux and receives the selected 4-bit digit code back.
- Decodes the code to segment patterns and walks the common anodes with a dead-time guard against ghosting.
- Sits between the vending-machine datapath (display mux) and the board pins.

Parameters:
- NUM_DIGITS, 6: digits scanned; mux_sel counts NUM_DIGITS-1 down to 0.
- REFRESH_DIV, 50000: clock cycles per digit slot (dead + on).
- DEAD_CYCLES, 4: cycles per slot with all anodes off; legal range 1 <= DEAD_CYCLES < REFRESH_DIV.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: scan enable.
- digit_data, input, 4: code of the currently selected digit, returned combinationally by the mux.
- dp_sel, input, NUM_DIGITS: decimal-point request per digit, active-high.
- mux_sel, output, 3: digit select to the mux.
- an, output, NUM_DIGITS: anodes, active-low.
- seg, output, 7: {g,f,e,d,c,b,a}, active-low.
- dp_n, output, 1: decimal point, active-low.
- frame_tick, output, 1: one-cycle pulse at frame start.

Behaviour:
- Reset (async, rst_n=0):
  - mux_sel=NUM_DIGITS-1, an=all 1s, seg=7'h7F, dp_n=1, frame_tick=0.
  - State DEAD, slot counter=0, nonzero flag cleared.
- Two states:
  - DEAD: an all 1s, lasts DEAD_CYCLES cycles.
  - ON: an[mux_sel]=0, others 1, lasts REFRESH_DIV-DEAD_CYCLES cycles.
  - Counter width: $clog2(REFRESH_DIV).
- DEAD->ON:
  - Occurs on the edge ending the last DEAD cycle.
  - On that same edge, seg loads decode(digit_data) and dp_n loads ~dp_sel[mux_sel].
  - seg and dp_n are held constant through ON, so data changes mid-slot never glitch the lit digit.
- ON->DEAD:
  - On the edge ending the last ON cycle, mux_sel decrements.
  - Wrap: 0 -> NUM_DIGITS-1; frame_tick=1 for exactly the first cycle with the new mux_sel=NUM_DIGITS-1.
  - mux_sel is stable for all DEAD_CYCLES before capture, which absorbs mux settling.
- Timing: slot = REFRESH_DIV cycles; frame = NUM_DIGITS*REFRESH_DIV cycles.
- Decode table:
  - 0..9: standard digits, e.g. 0=7'h40, 1=7'h79, 8=7'h00.
  - 4'hA: blank, 7'h7F (the mux's out-of-range code).
  - 4'hB: dash, 7'h3F.
  - 4'hC..4'hF: blank.
- en=0:
  - Synchronously forces state DEAD, counter=0, mux_sel=NUM_DIGITS-1.
  - an all 1s, seg=7'h7F, dp_n=1, frame_tick=0.
  - On re-enable, the first frame_tick does NOT fire, because the scan is already at frame start.
- Reset mid-slot: immediate async return to reset values, with no partial slot completed.
- REFRESH_DIV=DEAD_CYCLES+1: ON lasts 1 cycle; this is legal.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - A nonzero flag is cleared at each frame start (mux_sel reload).
  - At capture, if digit_data==0, the flag is clear and mux_sel!=0, seg loads 7'h7F instead of 7'h40.
  - The flag sets when a captured code is not 0 and not 4'hA.
  - Digit 0 is never suppressed; dp_n is unaffected.
- When undefined: the flag logic is absent and zeros always display 7'h40.

Decomposition:
- Package seven_seg_pkg holds:
  - Code constants: CODE_BLANK=4'hA, CODE_DASH=4'hB.
  - Segment pattern constants: SEG_BLANK=7'h7F and patterns for digits 0-9 and dash.
  - Scan state encoding: DEAD, ON.
- One combinational sub-module, seven_seg_decoder (4-bit code -> 7-bit active-low pattern), is instantiated once.
- Counters, FSM and capture stay in seven_seg_scan_ctrl.

Test Plan:
- Reset/first slot, with REFRESH_DIV=8, DEAD_CYCLES=2, en=1 after reset:
  - mux_sel=5, an=6'h3F for 2 cycles.
  - Then an=6'b011111 for 6 cycles.
  - seg = decode of digit_data present at capture.
- Full frame, mux model with digits 5..0 = 1,2,3,4,5,6:
  - mux_sel sequence 5,4,3,2,1,0 at 8-cycle spacing.
  - frame_tick pulses every 48 cycles, coincident with mux_sel 0->5.
  - seg per digit equals the table.
- Mid-slot change: alter digit_data during ON -> seg is unchanged until the next capture.
- Codes A/B/F with dp_sel=6'b000100 -> seg 7'h7F / 7'h3F / 7'h7F; dp_n=0 only while an[2]=0.
- en deassert mid-ON -> next cycle an=6'h3F, mux_sel=5, seg=7'h7F; re-enable restarts at slot 5 DEAD with no frame_tick.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN, digits 0,0,1,0,0,0 (5..0):
  - Digits 5 and 4 blank (7'h7F).
  - Digits 3..1 show 0/1 as decoded.
  - Digit 0 shows 7'h40.
  - With all-zero input, only digit 0 is lit.
